// File: rtl/lab3_mem_pkg.sv
// lab3_mem_pkg: shared widths, entry type and pointer-width helper for the
// store buffer slice that sits in front of datamemory.
package lab3_mem_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_entry_t;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int SB_PTR_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sb_entry_fifo.sv
// sb_entry_fifo: store-buffer entry storage, FIFO pointers and occupancy.
// With STORE_BUFFER_FWD_EN defined it adds an address CAM reporting the youngest match.
module sb_entry_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = lab3_mem_pkg::AW,
  parameter int DW    = lab3_mem_pkg::DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [AW-1:0] pushAddr,
  input  logic [DW-1:0] pushData,
  input  logic          pop,
  output logic [AW-1:0] headAddr,
  output logic [DW-1:0] headData,
  output logic          full,
  output logic          empty
`ifdef STORE_BUFFER_FWD_EN
  ,
  input  logic [AW-1:0] lookupAddr,
  output logic          fwdHit,
  output logic [DW-1:0] fwdData
`endif
);

  import lab3_mem_pkg::*;

  localparam int PTR_W = SB_PTR_W(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [AW-1:0]    addrMem [DEPTH];
  logic [DW-1:0]    dataMem [DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] wrPtrNext;
  logic [PTR_W-1:0] rdPtrReg;
  logic [PTR_W-1:0] rdPtrNext;
  logic [PTR_W:0]   countReg;
  logic [PTR_W:0]   countNext;

  assign full     = (countReg == FULL_COUNT);
  assign empty    = (countReg == '0);
  assign headAddr = addrMem[rdPtrReg];
  assign headData = dataMem[rdPtrReg];

  always_comb begin
    wrPtrNext = wrPtrReg;
    rdPtrNext = rdPtrReg;
    countNext = countReg;
    if (push) begin
      wrPtrNext = wrPtrReg + PTR_W'(1);
    end
    if (pop) begin
      rdPtrNext = rdPtrReg + PTR_W'(1);
    end
    if (push && !pop) begin
      countNext = countReg + (PTR_W + 1)'(1);
    end else if (!push && pop) begin
      countNext = countReg - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      wrPtrReg <= wrPtrNext;
      rdPtrReg <= rdPtrNext;
      countReg <= countNext;
    end
  end

  // Payload needs no reset: an entry is only ever read while it is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtrReg] <= pushAddr;
      dataMem[wrPtrReg] <= pushData;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [DEPTH-1:0] matchVec;
  logic [PTR_W-1:0] fwdSel;
  logic [PTR_W-1:0] searchIdx;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : gCam
    logic validReg;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        validReg <= 1'b0;
      end else if (push && (wrPtrReg == PTR_W'(gi))) begin
        validReg <= 1'b1;
      end else if (pop && (rdPtrReg == PTR_W'(gi))) begin
        validReg <= 1'b0;
      end
    end

    assign matchVec[gi] = validReg && (addrMem[gi] == lookupAddr);
  end

  // Walk oldest to youngest from the head; the last hit seen is the youngest.
  always_comb begin
    fwdHit    = 1'b0;
    fwdSel    = '0;
    searchIdx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      searchIdx = rdPtrReg + PTR_W'(k);
      if (matchVec[searchIdx]) begin
        fwdHit = 1'b1;
        fwdSel = searchIdx;
      end
    end
  end

  assign fwdData = dataMem[fwdSel];
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store queue in front of datamemory; loads win over draining.
// Define STORE_BUFFER_FWD_EN to forward buffered store data to loads (loads always ready).
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = lab3_mem_pkg::AW,
  parameter int DW    = lab3_mem_pkg::DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          idle
);

  import lab3_mem_pkg::*;

  logic          full;
  logic          empty;
  logic [AW-1:0] headAddr;
  logic [DW-1:0] headData;
  logic          loadReady;
  logic          storeFire;
  logic          loadFire;
  logic          drain;
  logic [DW-1:0] loadData;
  logic          rspValidReg;
  logic [DW-1:0] rspRdataReg;

`ifdef STORE_BUFFER_FWD_EN
  logic          fwdHit;
  logic [DW-1:0] fwdData;

  assign loadReady = 1'b1;
  assign loadData  = fwdHit ? fwdData : mem_rdata;
`else
  // Without a CAM a load can only be correct once every older store has landed.
  assign loadReady = empty;
  assign loadData  = mem_rdata;
`endif

  assign req_ready = req_we ? ~full : loadReady;
  assign storeFire = req_valid & req_we & ~full;
  assign loadFire  = req_valid & ~req_we & loadReady;
  // Gating with reset_n keeps a discarded entry from reaching memory on the reset edge.
  assign drain     = reset_n & ~empty & ~loadFire;

  sb_entry_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) entryFifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (storeFire),
    .pushAddr   (req_addr),
    .pushData   (req_wdata),
    .pop        (drain),
    .headAddr   (headAddr),
    .headData   (headData),
    .full       (full),
    .empty      (empty)
`ifdef STORE_BUFFER_FWD_EN
    ,
    .lookupAddr (req_addr),
    .fwdHit     (fwdHit),
    .fwdData    (fwdData)
`endif
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (loadFire) begin
      mem_addr = req_addr;
    end else if (drain) begin
      mem_we    = 1'b1;
      mem_addr  = headAddr;
      mem_wdata = headData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rspValidReg <= 1'b0;
      rspRdataReg <= '0;
    end else begin
      rspValidReg <= loadFire;
      if (loadFire) begin
        rspRdataReg <= loadData;
      end
    end
  end

  assign rsp_valid = rspValidReg;
  assign rsp_rdata = rspRdataReg;
  assign idle      = empty & ~rspValidReg;

endmodule
